// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants, state encoding and helper functions for
//               the 4-lane FIR MAC scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int NUM_LANES = 4;             // parallel MAC lanes == RAM banks
  localparam int COEFF_W   = 16;            // coefficient word width
  localparam int CADDR_W   = 6;             // global coefficient address / N
  localparam int LADDR_W   = CADDR_W - 2;   // per-bank local address
  localparam int ROUND_W   = LADDR_W + 1;   // holds R = ceil(N/4) up to 16

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UPDATE = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_MAC    = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_LATCH  = 3'd5
  } state_t;

  // Number of MAC rounds for N taps: ceil(N/4).
  function automatic logic [ROUND_W-1:0] ceilDiv4(input logic [CADDR_W-1:0] n);
    return ROUND_W'(({1'b0, n} + (CADDR_W+1)'(3)) >> 2);
  endfunction

  // Lane j in round r carries tap 4r+j; it is live only while that tap exists.
  function automatic logic [NUM_LANES-1:0] laneMask(input logic [LADDR_W-1:0] r,
                                                    input logic [CADDR_W-1:0] n);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      m[j] = ({r, 2'(j)} < n);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_lane_mask.sv
`default_nettype none
// ============================================================================
// Module      : fir_lane_mask
// Description : Combinational per-lane product enable for a MAC round, so
//               the coefficient banks never need zero padding past tap N-1.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_lane_mask
  import fir_pkg::*;
(
  input  logic [LADDR_W-1:0]   iRound,
  input  logic [CADDR_W-1:0]   iNumCoeff,
  output logic [NUM_LANES-1:0] oLaneEn
);

  // enable exactly the lanes whose tap index 4*round+lane is below N
  always_comb begin
    oLaneEn = laneMask(iRound, iNumCoeff);
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_scheduler
// Description : Control sequencer for the 4-lane FIR datapath. Maps external
//               coefficient writes onto the four RAM banks in update mode and
//               runs ceil(N/4) masked MAC rounds per sample strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_scheduler
  import fir_pkg::*;
(
  input  logic                 iClk12M,
  input  logic                 iRsn,
  input  logic                 iEnSample600k,
  input  logic                 iCoeffUpdateFlag,
  input  logic [CADDR_W-1:0]   iAddrRam,
  input  logic [COEFF_W-1:0]   iWrDtRam,
  input  logic [CADDR_W-1:0]   iNumOfCoeff,
  output logic [NUM_LANES-1:0] oCsRam,
  output logic [NUM_LANES-1:0] oWeRam,
  output logic [LADDR_W-1:0]   oAddrRam,
  output logic [COEFF_W-1:0]   oWrDtRam,
  output logic                 oShiftEn,
  output logic                 oAccClr,
  output logic                 oAccEn,
  output logic [NUM_LANES-1:0] oLaneEn,
  output logic [LADDR_W-1:0]   oTapSel,
  output logic                 oOutLatch,
  output logic                 oBusy,
  output logic                 oDropSample
);

  state_t               r_state;
  logic [CADDR_W-1:0]   r_numCoeff;   // N latched at the accepted strobe
  logic [ROUND_W-1:0]   r_numRounds;  // R = ceil(N/4)
  logic [LADDR_W-1:0]   r_roundCnt;   // current MAC round r
  logic                 r_macRd;      // a MAC read is on the RAM bus this cycle
  logic [NUM_LANES-1:0] w_laneMask;
  logic                 w_lastRound;
  logic [NUM_LANES-1:0] w_bankSel;

  fir_lane_mask u_laneMask (
    .iRound    (r_roundCnt),
    .iNumCoeff (r_numCoeff),
    .oLaneEn   (w_laneMask)
  );

  // final round reached when the next round index would equal R; bank select from address LSBs
  always_comb begin
    w_lastRound = (({1'b0, r_roundCnt} + ROUND_W'(1)) == r_numRounds);
    w_bankSel   = NUM_LANES'(1) << iAddrRam[1:0];
  end

  // sequencer: state, counters and every registered output
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      r_state     <= ST_IDLE;
      r_numCoeff  <= '0;
      r_numRounds <= '0;
      r_roundCnt  <= '0;
      r_macRd     <= 1'b0;
      oCsRam      <= '0;
      oWeRam      <= '0;
      oAddrRam    <= '0;
      oWrDtRam    <= '0;
      oShiftEn    <= 1'b0;
      oAccClr     <= 1'b0;
      oAccEn      <= 1'b0;
      oLaneEn     <= '0;
      oTapSel     <= '0;
      oOutLatch   <= 1'b0;
      oBusy       <= 1'b0;
      oDropSample <= 1'b0;
    end else begin
      // single-cycle controls default low; RAM bus idles with no selects
      oShiftEn    <= 1'b0;
      oAccClr     <= 1'b0;
      oOutLatch   <= 1'b0;
      oDropSample <= 1'b0;
      oCsRam      <= '0;
      oWeRam      <= '0;
      oAddrRam    <= '0;
      r_macRd     <= 1'b0;

      // accumulate stage trails the RAM read by one cycle (read latency)
      oAccEn  <= r_macRd;
      oTapSel <= r_macRd ? r_roundCnt : '0;
      oLaneEn <= r_macRd ? w_laneMask : '0;

      unique case (r_state)
        ST_IDLE: begin
          if (iCoeffUpdateFlag) begin
            // update request wins; a coincident strobe is dropped
            r_state     <= ST_UPDATE;
            oBusy       <= 1'b1;
            oDropSample <= iEnSample600k;
          end else if (iEnSample600k) begin
            r_numCoeff  <= iNumOfCoeff;
            r_numRounds <= ceilDiv4(iNumOfCoeff);
            r_state     <= ST_SHIFT;
            oBusy       <= 1'b1;
            oShiftEn    <= 1'b1;
            oAccClr     <= 1'b1;
          end else begin
            oBusy <= 1'b0;
          end
        end

        ST_UPDATE: begin
          oDropSample <= iEnSample600k;
          if (iCoeffUpdateFlag) begin
            oCsRam   <= w_bankSel;
            oWeRam   <= w_bankSel;
            oAddrRam <= iAddrRam[CADDR_W-1:2];
            oWrDtRam <= iWrDtRam;
          end else begin
            r_state <= ST_IDLE;
            oBusy   <= 1'b0;
          end
        end

        ST_SHIFT: begin
          oDropSample <= iEnSample600k;
          r_roundCnt  <= '0;
          if (r_numRounds != '0) begin
            r_state  <= ST_MAC;
            oCsRam   <= '1;
            r_macRd  <= 1'b1;
          end else begin
            r_state <= ST_DRAIN;
          end
        end

        ST_MAC: begin
          oDropSample <= iEnSample600k;
          if (w_lastRound) begin
            r_state <= ST_DRAIN;
          end else begin
            r_roundCnt <= r_roundCnt + LADDR_W'(1);
            oAddrRam   <= r_roundCnt + LADDR_W'(1);
            oCsRam     <= '1;
            r_macRd    <= 1'b1;
          end
        end

        ST_DRAIN: begin
          oDropSample <= iEnSample600k;
          r_state     <= ST_LATCH;
          oOutLatch   <= 1'b1;
        end

        ST_LATCH: begin
          oDropSample <= iEnSample600k;
          r_state     <= ST_IDLE;
          oBusy       <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_scheduler
// Description : Self-checking bench for fir_mac_scheduler: vector table of
//               tap counts, directed corner sequences, and a randomized run
//               against a timing-offset reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_scheduler;

  logic        iClk12M = 1'b0;
  logic        iRsn;
  logic        iEnSample600k;
  logic        iCoeffUpdateFlag;
  logic [5:0]  iAddrRam;
  logic [15:0] iWrDtRam;
  logic [5:0]  iNumOfCoeff;
  logic [3:0]  oCsRam;
  logic [3:0]  oWeRam;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic        oShiftEn;
  logic        oAccClr;
  logic        oAccEn;
  logic [3:0]  oLaneEn;
  logic [3:0]  oTapSel;
  logic        oOutLatch;
  logic        oBusy;
  logic        oDropSample;

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;

  fir_mac_scheduler dut (
    .iClk12M          (iClk12M),
    .iRsn             (iRsn),
    .iEnSample600k    (iEnSample600k),
    .iCoeffUpdateFlag (iCoeffUpdateFlag),
    .iAddrRam         (iAddrRam),
    .iWrDtRam         (iWrDtRam),
    .iNumOfCoeff      (iNumOfCoeff),
    .oCsRam           (oCsRam),
    .oWeRam           (oWeRam),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oShiftEn         (oShiftEn),
    .oAccClr          (oAccClr),
    .oAccEn           (oAccEn),
    .oLaneEn          (oLaneEn),
    .oTapSel          (oTapSel),
    .oOutLatch        (oOutLatch),
    .oBusy            (oBusy),
    .oDropSample      (oDropSample)
  );

  always #5 iClk12M = ~iClk12M;

  always @(posedge iClk12M) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] outVec();
    return {oCsRam, oWeRam, oAddrRam, oWrDtRam, oShiftEn, oAccClr, oAccEn,
            oLaneEn, oTapSel, oOutLatch, oBusy, oDropSample};
  endfunction

  task automatic nextCycle();
    @(posedge iClk12M);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: a sample accepted in cycle t occupies t+1..t+3+R; every
  // output is a function of the offset k = c - t. Update mode mirrors the
  // flag with one cycle of registration.
  // --------------------------------------------------------------------------
  logic        pValid = 1'b0;
  logic        pRsn, pStrobe, pFlag;
  logic [5:0]  pAddr, pN;
  logic [15:0] pData;
  bit          mSamp = 1'b0;
  bit          mUpd  = 1'b0;
  int          mT = 0, mR = 0, mN = 0;
  logic [15:0] mWrDt = '0;

  always @(negedge iClk12M) begin : model
    logic [3:0]  eCs, eWe, eAddr, eLane, eTap;
    logic        eShift, eClr, eAcc, eLatch, eBusy, eDrop;
    int          c, k;
    bit          prevBusy;
    c = cyc;
    eCs = '0; eWe = '0; eAddr = '0; eLane = '0; eTap = '0;
    eShift = 1'b0; eClr = 1'b0; eAcc = 1'b0; eLatch = 1'b0; eBusy = 1'b0; eDrop = 1'b0;
    if (pValid) begin
      if (!pRsn) begin
        mSamp = 1'b0;
        mUpd  = 1'b0;
        mWrDt = '0;
      end else begin
        prevBusy = mUpd || (mSamp && (c - 1) >= mT + 1 && (c - 1) <= mT + 3 + mR);
        if (!prevBusy) begin
          if (pFlag) begin
            mUpd  = 1'b1;
            eDrop = pStrobe;
          end else if (pStrobe) begin
            mSamp = 1'b1;
            mT    = c - 1;
            mN    = int'(pN);
            mR    = (mN + 3) / 4;
          end
        end else begin
          eDrop = pStrobe;
          if (mUpd) begin
            if (pFlag) begin
              eCs   = 4'(1) << pAddr[1:0];
              eWe   = eCs;
              eAddr = pAddr[5:2];
              mWrDt = pData;
            end else begin
              mUpd = 1'b0;
            end
          end
        end
        if (mSamp) begin
          k = c - mT;
          eBusy  = (k >= 1 && k <= 3 + mR);
          eShift = (k == 1);
          eClr   = (k == 1);
          if (k >= 2 && k <= 1 + mR) begin
            eCs   = 4'hF;
            eAddr = 4'(k - 2);
          end
          if (k >= 3 && k <= 2 + mR) begin
            eAcc = 1'b1;
            eTap = 4'(k - 3);
            for (int j = 0; j < 4; j++) eLane[j] = (4 * (k - 3) + j < mN);
          end
          eLatch = (k == 3 + mR);
        end
      end
      eBusy = eBusy | mUpd;
      check($sformatf("model_c%0d", c), 64'(outVec()),
            64'({eCs, eWe, eAddr, mWrDt, eShift, eClr, eAcc, eLane, eTap, eLatch, eBusy, eDrop}));
    end
    pValid  = 1'b1;
    pRsn    = iRsn;
    pStrobe = iEnSample600k;
    pFlag   = iCoeffUpdateFlag;
    pAddr   = iAddrRam;
    pN      = iNumOfCoeff;
    pData   = iWrDtRam;
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  task automatic runSample(input logic [5:0] n, output int latchOff, output int accCnt,
                           output logic [3:0] lastLane, output int idleOff);
    int t;
    latchOff = -1; accCnt = 0; lastLane = '0; idleOff = -1;
    nextCycle();
    iEnSample600k = 1'b1;
    iNumOfCoeff   = n;
    t = cyc;
    nextCycle();
    iEnSample600k = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge iClk12M);
      if (oOutLatch && latchOff < 0) latchOff = cyc - t;
      if (oAccEn) begin
        accCnt++;
        lastLane = oLaneEn;
      end
      if (!oBusy && idleOff < 0) idleOff = cyc - t;
      nextCycle();
    end
  endtask

  task automatic settle(input int n);
    iEnSample600k    = 1'b0;
    iCoeffUpdateFlag = 1'b0;
    repeat (n) nextCycle();
  endtask

  typedef struct {
    logic [5:0] n;
    int         expLatch;
    int         expAcc;
    logic [3:0] expLastLane;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int         latchOff, accCnt, idleOff, t, drops, latches;
    logic [3:0] lastLane;
    logic [15:0] v;

    vecs[0] = '{6'd0,  3,  0,  4'b0000};
    vecs[1] = '{6'd1,  4,  1,  4'b0001};
    vecs[2] = '{6'd4,  4,  1,  4'b1111};
    vecs[3] = '{6'd5,  5,  2,  4'b0001};
    vecs[4] = '{6'd8,  5,  2,  4'b1111};
    vecs[5] = '{6'd21, 9,  6,  4'b0001};
    vecs[6] = '{6'd62, 19, 16, 4'b0011};
    vecs[7] = '{6'd63, 19, 16, 4'b0111};

    iRsn = 1'b0; iEnSample600k = 1'b0; iCoeffUpdateFlag = 1'b0;
    iAddrRam = '0; iWrDtRam = '0; iNumOfCoeff = '0;

    // reset state
    repeat (3) nextCycle();
    @(negedge iClk12M);
    check("reset_outputs", 64'(outVec()), 64'd0);
    nextCycle();
    iRsn = 1'b1;
    settle(3);

    // tap-count table
    for (int i = 0; i < 8; i++) begin
      runSample(vecs[i].n, latchOff, accCnt, lastLane, idleOff);
      check($sformatf("latch_n%0d", vecs[i].n), 64'(latchOff), 64'(vecs[i].expLatch));
      check($sformatf("acccnt_n%0d", vecs[i].n), 64'(accCnt), 64'(vecs[i].expAcc));
      check($sformatf("lastlane_n%0d", vecs[i].n), 64'(lastLane), 64'(vecs[i].expLastLane));
      check($sformatf("idle_n%0d", vecs[i].n), 64'(idleOff), 64'(vecs[i].expLatch + 1));
      settle(2);
    end

    // coefficient update writes, with a strobe that must be dropped
    nextCycle();
    iCoeffUpdateFlag = 1'b1;
    for (int a = 0; a <= 21; a++) begin
      nextCycle();
      if (a <= 20) begin
        case (a)
          0:       v = 16'd13;
          1:       v = 16'd0;
          2:       v = 16'hFFED;
          10:      v = 16'd500;
          default: v = 16'(a * 37 - 100);
        endcase
        iAddrRam = 6'(a);
        iWrDtRam = v;
      end
      iEnSample600k = (a == 5);
      if (a == 21) iCoeffUpdateFlag = 1'b0;
      @(negedge iClk12M);
      if (a == 6) check("update_strobe_drop", 64'(oDropSample), 64'd1);
      if (a == 11) begin
        check("upd_a10_cs", 64'(oCsRam), 64'b0100);
        check("upd_a10_we", 64'(oWeRam), 64'b0100);
        check("upd_a10_addr", 64'(oAddrRam), 64'd2);
        check("upd_a10_data", 64'(oWrDtRam), 64'd500);
      end
    end
    settle(3);

    // N=21 with an intruding strobe at t+5
    nextCycle();
    iEnSample600k = 1'b1;
    iNumOfCoeff   = 6'd21;
    t = cyc;
    for (int k = 1; k <= 12; k++) begin
      logic       eAcc;
      logic [3:0] eTap, eLane;
      nextCycle();
      iEnSample600k = (k == 5);
      @(negedge iClk12M);
      eAcc  = (k >= 3 && k <= 8);
      eTap  = eAcc ? 4'(k - 3) : 4'd0;
      eLane = eAcc ? ((k == 8) ? 4'b0001 : 4'hF) : 4'd0;
      check($sformatf("n21_k%0d", cyc - t), 64'({oAccEn, oTapSel, oLaneEn, oOutLatch, oDropSample}),
            64'({eAcc, eTap, eLane, (k == 9), (k == 6)}));
    end
    settle(3);

    // update flag raised mid-sample; strobe coinciding with flag in IDLE
    nextCycle();
    iEnSample600k = 1'b1;
    iNumOfCoeff   = 6'd21;
    for (int k = 1; k <= 12; k++) begin
      nextCycle();
      iEnSample600k    = (k == 10);
      iCoeffUpdateFlag = (k >= 4 && k <= 11);
      @(negedge iClk12M);
      if (k == 9)  check("flag_latch_t9", 64'(oOutLatch), 64'd1);
      if (k == 10) check("flag_idle_t10", 64'(oBusy), 64'd0);
      if (k == 11) check("flag_update_t11", 64'({oBusy, oDropSample, oWeRam}), 64'({1'b1, 1'b1, 4'd0}));
    end
    settle(3);

    // reset asserted during MAC
    nextCycle();
    iEnSample600k = 1'b1;
    iNumOfCoeff   = 6'd21;
    nextCycle();
    iEnSample600k = 1'b0;
    repeat (3) nextCycle();
    iRsn = 1'b0;
    nextCycle();
    iRsn = 1'b1;
    @(negedge iClk12M);
    check("reset_mid_mac", 64'(outVec()), 64'd0);
    runSample(6'd21, latchOff, accCnt, lastLane, idleOff);
    check("post_reset_latch", 64'(latchOff), 64'd9);
    check("post_reset_acc", 64'(accCnt), 64'd6);
    settle(2);

    // back-to-back worst-case samples 20 cycles apart
    drops = 0;
    latches = 0;
    for (int k = 0; k < 62; k++) begin
      nextCycle();
      iEnSample600k = ((k % 20) == 0) && (k < 60);
      iNumOfCoeff   = 6'd63;
      @(negedge iClk12M);
      drops   += int'(oDropSample);
      latches += int'(oOutLatch);
    end
    check("b2b_drops", 64'(drops), 64'd0);
    check("b2b_latches", 64'(latches), 64'd3);
    settle(3);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      nextCycle();
      iEnSample600k = ($urandom_range(0, 7) == 0);
      iNumOfCoeff   = 6'($urandom_range(0, 63));
      iAddrRam      = 6'($urandom);
      iWrDtRam      = 16'($urandom);
      if (iCoeffUpdateFlag) iCoeffUpdateFlag = ($urandom_range(0, 9) != 0);
      else                  iCoeffUpdateFlag = ($urandom_range(0, 119) == 0);
      iRsn = ($urandom_range(0, 399) != 0);
    end
    iRsn = 1'b1;
    settle(30);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Control sequencer for the 4-lane FIR datapath in `DUT_top`. It owns the four coefficient RAM banks and the MAC accumulator controls. In update mode it maps the external coefficient writes onto the banks. On each 600 kHz sample strobe it runs ceil(N/4) MAC rounds, masks the lanes beyond N, and pulses the output latch. Because the trailing lanes are masked, coefficient memory no longer needs zero padding.

## Interface
- NUM_LANES, 4, parallel MAC lanes; also the number of coefficient banks. Coefficient k lives in bank k%4 at local address k/4.
- COEFF_W, 16, coefficient word width.
- CADDR_W, 6, width of the global coefficient address and of N.
- LADDR_W, 4, width of the per-bank local address (CADDR_W-2).

- iClk12M  in  1  system clock, 12 MHz.
- iRsn  in  1  synchronous active-low reset.
- iEnSample600k  in  1  one-cycle sample strobe.
- iCoeffUpdateFlag  in  1  level signal; high requests update mode.
- iAddrRam  in  6  global coefficient write address.
- iWrDtRam  in  16  coefficient write data.
- iNumOfCoeff  in  6  tap count N (0..63).
- oCsRam  out  4  per-bank chip select.
- oWeRam  out  4  per-bank write enable.
- oAddrRam  out  4  bank-local address, shared by all banks.
- oWrDtRam  out  16  registered write data.
- oShiftEn  out  1  advance the input delay line.
- oAccClr  out  1  clear the accumulator.
- oAccEn  out  1  accumulate this cycle's lane products.
- oLaneEn  out  4  per-lane product enable, valid while oAccEn is high.
- oTapSel  out  4  round index used by the delay-line tap mux; aligned with oAccEn.
- oOutLatch  out  1  load the FIR output register.
- oBusy  out  1  high in any state other than IDLE.
- oDropSample  out  1  one-cycle pulse when a strobe is ignored.

## Operation
- States: IDLE, UPDATE, SHIFT, MAC, DRAIN, LATCH.
- IDLE:
  - If iCoeffUpdateFlag is high, go to UPDATE. The flag has priority over a simultaneous strobe; that strobe is dropped.
  - Otherwise, on iEnSample600k, latch N = iNumOfCoeff and R = ceil(N/4), then go to SHIFT.
- UPDATE, evaluated every cycle:
  - oCsRam = oWeRam = onehot(iAddrRam[1:0]), registered.
  - oAddrRam = iAddrRam[5:2], registered.
  - oWrDtRam = iWrDtRam, registered.
  - Repeated writes to the same address are legal.
  - When the flag falls, return to IDLE. The last write issued is the one for the cycle in which the flag was still high.
- SHIFT, one cycle:
  - oShiftEn=1 and oAccClr=1.
  - Then go to MAC if R>0, otherwise to DRAIN.
- MAC, R cycles:
  - Round counter r runs 0..R-1.
  - oCsRam=4'hF, oWeRam=0, oAddrRam=r.
  - On r=R-1, go to DRAIN.
- Accumulate pipeline: oAccEn, oTapSel and oLaneEn are the MAC-cycle values delayed by one cycle, matching the 1-cycle RAM read latency. Lane j is enabled iff 4r+j < N.
- DRAIN: one cycle; absorbs the final delayed accumulate.
- LATCH: one cycle with oOutLatch=1, then return to IDLE.
- Update request during a computation: the request is honoured only on reaching IDLE. The current sample always completes.
- Strobe arriving while not in IDLE: ignored, oDropSample=1 for one cycle, and the latched N is unchanged.
- Reset, including mid-operation:
  - State returns to IDLE and the counter to 0.
  - All outputs reset to 0, including oWeRam, so no write is issued during reset.

## Timing
- Take the strobe in cycle t:
  - SHIFT occurs in t+1.
  - MAC reads occur in t+2..t+1+R.
  - oAccEn is high in t+3..t+2+R.
  - oOutLatch is high in t+3+R.
  - The block is back in IDLE at t+4+R.
- Worst case N=63 (R=16): IDLE at t+20, which exactly fits the 20-cycle sample period.
- N=0: SHIFT, DRAIN, LATCH only. oAccEn is never asserted and the latch loads the cleared accumulator at t+3.
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- Shared package fir_pkg holds:
  - The NUM_LANES, COEFF_W, CADDR_W and LADDR_W constants.
  - The state enum.
  - A function computing ceil(N/4).
  - A function computing the lane mask from (r, N).
- One sub-module, fir_lane_mask: combinational lane-enable generation from r and N; it is reused by the datapath assertions.

## Test plan
- Update writes: flag high, writes to addr 0..20 with values 13, 0, -19, … .
  - addr 10 (value 500) gives oCsRam=oWeRam=4'b0100, oAddrRam=2, oWrDtRam=500 one cycle later.
  - No strobe is accepted while in UPDATE.
- N=21: strobe at t.
  - oAccEn is high in t+3..t+8 with oTapSel 0..5.
  - oLaneEn=4'hF for rounds 0..4 and 4'b0001 for round 5.
  - oOutLatch at t+9.
- N=0 and N=63:
  - N=0: oOutLatch at t+3 with no oAccEn.
  - N=63: oOutLatch at t+19, last oLaneEn=4'b0111, oBusy low at t+20.
  - Back-to-back strobes 20 cycles apart are never dropped.
- Strobe at t+5 during an N=21 sample: oDropSample pulses at t+6 and the sequence timing is unchanged.
- Flag raised at t+4: the sample completes (oOutLatch at t+9), then UPDATE begins at t+11.
  - A strobe coinciding with the flag in IDLE is dropped.
- iRsn low during MAC: one cycle later all outputs are 0 and the state is IDLE.
  - A strobe after reset release gives a full clean sequence.
